stage_classifier_sequencer: RTL and testbench
=============================================

Name: stage_classifier_sequencer

Overview:
- Consumes the flattened stage parameter array produced by the stage database loader once its ready flag is high.
- Walks the classifiers of one stage in order. For each classifier it presents that classifier's parameters to the Haar feature evaluator over a valid/ready handshake, then collects the evaluator's signed vote.
- Accumulates the votes and compares the stage sum against the stage threshold held in the same array.
- Reports pass/fail for the stage. It is the read-side counterpart of the loader and sits between the database and the evaluator.

Parameters:
DATA_WIDTH_16, 16, width of every database word and of a vote
NUM_CLASSIFIERS, 10, classifiers per stage
NUM_PARAM_PER_CLASSIFIER, 19, words per classifier
NUM_STAGE_THRESHOLD, 3, trailing stage words; word 0 is the signed stage threshold, words 1-2 are ignored
ACC_WIDTH, 20, stage accumulator width; must be >= DATA_WIDTH_16+clog2(NUM_CLASSIFIERS)

Ports:
clk_fpga  in  1  clock
reset_fpga  in  1  asynchronous active-high reset
i_db_ready  in  1  database array valid
i_rom  in  (NUM_CLASSIFIERS*NUM_PARAM_PER_CLASSIFIER+NUM_STAGE_THRESHOLD)*DATA_WIDTH_16  flattened array; word w occupies bits [w*16+15:w*16]
i_start  in  1  request a stage evaluation (pulse)
o_busy  out  1  evaluation in progress
o_param_valid  out  1  o_params/o_classifier_index valid
i_param_ready  in  1  evaluator accepts parameters
o_classifier_index  out  clog2(NUM_CLASSIFIERS) (min 1)  current classifier
o_params  out  NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_16  words k*19..k*19+18 of classifier k, word 0 in the LSBs
i_vote_valid  in  1  vote present
i_vote  in  DATA_WIDTH_16  signed two's-complement vote
o_done  out  1  one-cycle result strobe
o_stage_pass  out  1  stage result, valid while o_done and held afterwards
o_stage_sum  out  ACC_WIDTH  signed final sum, held with o_stage_pass

Behaviour:
- Reset: state IDLE; index 0; accumulator 0. o_busy, o_param_valid, o_done and o_stage_pass are 0. o_params and o_stage_sum are 0.
- States:
  - IDLE -> ISSUE when i_start && i_db_ready. On that edge: clear accumulator, index=0, register the o_params slice for classifier 0. o_param_valid and o_busy go high the next cycle (1-cycle latency).
  - ISSUE: o_param_valid=1. o_params and o_classifier_index are held stable until the handshake. On i_param_ready -> WAIT_VOTE; o_param_valid drops the next cycle.
  - WAIT_VOTE: on i_vote_valid, acc <= acc + sign_extend(i_vote).
    - Index < NUM_CLASSIFIERS-1: index+1, register the next slice -> ISSUE.
    - Last index: register o_stage_sum = acc+vote and o_stage_pass = ((acc+vote) >= sign_extend(threshold word)) -> DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 in this cycle -> IDLE.
- Arithmetic: all signed, ACC_WIDTH bits. No saturation is needed; the width guarantees no overflow.
- Boundaries:
  - i_start while busy, or while i_db_ready=0: ignored, not queued.
  - i_vote_valid outside WAIT_VOTE: ignored.
  - i_vote_valid in the same cycle as the ISSUE handshake: ignored; a vote counts only in WAIT_VOTE.
  - i_db_ready falls while busy: abort to IDLE next cycle. o_busy and o_param_valid go 0, no o_done, previous o_stage_pass/o_stage_sum retained.
  - NUM_CLASSIFIERS=1: ISSUE -> WAIT_VOTE -> DONE.
  - Reset mid-operation: all reset values apply immediately (asynchronous).
- Back-to-back: i_start in the DONE cycle is ignored. i_start is accepted from IDLE in the following cycle.

Decomposition:
- Shared package stage_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT_VOTE, DONE);
  - localparams ROM_WORDS = NUM_CLASSIFIERS*NUM_PARAM_PER_CLASSIFIER+NUM_STAGE_THRESHOLD, THRESH_BASE = NUM_CLASSIFIERS*NUM_PARAM_PER_CLASSIFIER, and the index width.
- One sub-module, stage_param_slicer: combinational mux selecting classifier k's 19 words from i_rom. The sequencer registers its output.

Test Plan:
- NUM_CLASSIFIERS=3. Votes +100, -50, +20; threshold word 60; evaluator ready held high -> o_done once; o_stage_sum=70; o_stage_pass=1; o_classifier_index sequence 0,1,2.
- Same setup with threshold 71 -> o_stage_pass=0, o_stage_sum=70. With threshold -32768 and votes all -32768 (3 of them) -> sum -98304, pass=0.
- i_param_ready held low 5 cycles on classifier 1 -> o_param_valid and o_params (word 0 = rom[19]) stable for all 5 cycles; no vote accepted early.
- i_start with i_db_ready=0 -> o_busy stays 0. A second i_start while busy -> exactly one o_done.
- i_db_ready deasserted in WAIT_VOTE of classifier 1 -> o_busy=0 next cycle, no o_done, prior result unchanged.
- reset_fpga pulsed mid ISSUE -> all outputs 0 asynchronously. A fresh i_start then completes normally from index 0.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared types and sizing helpers for the stage classifier sequencer and its
// parameter slicer.
package stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VOTE,
    ST_DONE
  } stage_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned thresh_base(input int unsigned nc, input int unsigned np);
    return nc * np;
  endfunction

  function automatic int unsigned rom_words(input int unsigned nc, input int unsigned np,
                                            input int unsigned nt);
    return nc * np + nt;
  endfunction

  localparam int unsigned DEF_NUM_CLASSIFIERS          = 10;
  localparam int unsigned DEF_NUM_PARAM_PER_CLASSIFIER = 19;
  localparam int unsigned DEF_NUM_STAGE_THRESHOLD      = 3;
  localparam int unsigned ROM_WORDS   = rom_words(DEF_NUM_CLASSIFIERS, DEF_NUM_PARAM_PER_CLASSIFIER,
                                                  DEF_NUM_STAGE_THRESHOLD);
  localparam int unsigned THRESH_BASE = thresh_base(DEF_NUM_CLASSIFIERS, DEF_NUM_PARAM_PER_CLASSIFIER);
  localparam int unsigned IDX_W       = idx_width(DEF_NUM_CLASSIFIERS);

endpackage

// File: rtl/stage_param_slicer.sv
// Combinational selector returning the parameter words of one classifier from
// the classifier region of the flattened stage array.
module stage_param_slicer
  import stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_16            = 16,
  parameter int unsigned NUM_CLASSIFIERS          = 10,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 19
) (
  input  logic [NUM_CLASSIFIERS*NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_16-1:0] i_rom,
  input  logic [idx_width(NUM_CLASSIFIERS)-1:0]                             i_index,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_16-1:0]                 o_params
);

  localparam int unsigned SEL_W   = idx_width(NUM_CLASSIFIERS);
  localparam int unsigned SLICE_W = NUM_PARAM_PER_CLASSIFIER * DATA_WIDTH_16;

  // Indices beyond the last classifier select all-zero.
  always_comb begin
    o_params = '0;
    for (int unsigned k = 0; k < NUM_CLASSIFIERS; k++) begin
      if (i_index == SEL_W'(k)) o_params = i_rom[k*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/stage_classifier_sequencer.sv
// Walks one stage's classifiers, hands each parameter set to the feature
// evaluator, accumulates the signed votes and reports pass/fail.
module stage_classifier_sequencer
  import stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_16            = 16,
  parameter int unsigned NUM_CLASSIFIERS          = 10,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int unsigned NUM_STAGE_THRESHOLD      = 3,
  parameter int unsigned ACC_WIDTH                = 20
) (
  input  logic clk_fpga,
  input  logic reset_fpga,
  input  logic i_db_ready,
  input  logic [(NUM_CLASSIFIERS*NUM_PARAM_PER_CLASSIFIER+NUM_STAGE_THRESHOLD)*DATA_WIDTH_16-1:0] i_rom,
  input  logic i_start,
  output logic o_busy,
  output logic o_param_valid,
  input  logic i_param_ready,
  output logic [idx_width(NUM_CLASSIFIERS)-1:0] o_classifier_index,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_16-1:0] o_params,
  input  logic i_vote_valid,
  input  logic [DATA_WIDTH_16-1:0] i_vote,
  output logic o_done,
  output logic o_stage_pass,
  output logic [ACC_WIDTH-1:0] o_stage_sum
);

  localparam int unsigned CIDX_W     = idx_width(NUM_CLASSIFIERS);
  localparam int unsigned SLICE_W    = NUM_PARAM_PER_CLASSIFIER * DATA_WIDTH_16;
  localparam int unsigned THRESH_LSB = thresh_base(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER) * DATA_WIDTH_16;
  localparam int unsigned ROM_BITS   = rom_words(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER,
                                                 NUM_STAGE_THRESHOLD) * DATA_WIDTH_16;
  localparam int unsigned EXT_W      = ACC_WIDTH - DATA_WIDTH_16;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_CLASSIFIERS - 1);

  stage_state_e                state_q;
  logic [CIDX_W-1:0]           idx_q;
  logic [CIDX_W-1:0]           slice_idx_d;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] vote_ext;
  logic signed [ACC_WIDTH-1:0] thresh_ext;
  logic [SLICE_W-1:0]          params_q;
  logic [SLICE_W-1:0]          slice_d;
  logic                        busy_q;
  logic                        param_valid_q;
  logic                        done_q;
  logic                        pass_q;
  logic                        unused_rom_tail;

  // The slicer looks one step ahead so the next slice is registered on the
  // same edge that advances the state.
  always_comb begin
    slice_idx_d = (state_q == ST_IDLE) ? '0 : idx_q + CIDX_W'(1);
  end

  assign vote_ext   = {{EXT_W{i_vote[DATA_WIDTH_16-1]}}, i_vote};
  assign thresh_ext = {{EXT_W{i_rom[THRESH_LSB+DATA_WIDTH_16-1]}},
                       i_rom[THRESH_LSB +: DATA_WIDTH_16]};
  assign acc_d      = acc_q + vote_ext;

  assign unused_rom_tail = ^i_rom[ROM_BITS-1:THRESH_LSB+DATA_WIDTH_16];

  stage_param_slicer #(
    .DATA_WIDTH_16           (DATA_WIDTH_16),
    .NUM_CLASSIFIERS         (NUM_CLASSIFIERS),
    .NUM_PARAM_PER_CLASSIFIER(NUM_PARAM_PER_CLASSIFIER)
  ) u_slicer (
    .i_rom   (i_rom[THRESH_LSB-1:0]),
    .i_index (slice_idx_d),
    .o_params(slice_d)
  );

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      sum_q         <= '0;
      params_q      <= '0;
      busy_q        <= 1'b0;
      param_valid_q <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start && i_db_ready) begin
            state_q       <= ST_ISSUE;
            idx_q         <= '0;
            acc_q         <= '0;
            params_q      <= slice_d;
            param_valid_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (!i_db_ready) begin
            state_q       <= ST_IDLE;
            param_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end else if (i_param_ready) begin
            state_q       <= ST_WAIT_VOTE;
            param_valid_q <= 1'b0;
          end
        end
        ST_WAIT_VOTE: begin
          if (!i_db_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (i_vote_valid) begin
            acc_q <= acc_d;
            if (idx_q == LAST_IDX) begin
              sum_q   <= acc_d;
              pass_q  <= (acc_d >= thresh_ext);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              idx_q         <= idx_q + CIDX_W'(1);
              params_q      <= slice_d;
              param_valid_q <= 1'b1;
              state_q       <= ST_ISSUE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy             = busy_q;
  assign o_param_valid      = param_valid_q;
  assign o_classifier_index = idx_q;
  assign o_params           = params_q;
  assign o_done             = done_q;
  assign o_stage_pass       = pass_q;
  assign o_stage_sum        = sum_q;

endmodule

// File: tb/tb_stage_classifier_sequencer.sv
// Directed bench for stage_classifier_sequencer with three classifiers per
// stage; expected sums and pass flags come from plain integer arithmetic.
module tb_stage_classifier_sequencer;

  localparam int DW    = 16;
  localparam int NC    = 3;
  localparam int NP    = 19;
  localparam int NT    = 3;
  localparam int AW    = 20;
  localparam int WORDS = NC*NP + NT;
  localparam int THR_W = NC*NP;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 db_ready;
  logic [WORDS*DW-1:0]  rom;
  logic                 start;
  logic                 busy;
  logic                 pv;
  logic                 pready;
  logic [1:0]           cidx;
  logic [NP*DW-1:0]     params;
  logic                 vv;
  logic [DW-1:0]        vote;
  logic                 done;
  logic                 pass;
  logic [AW-1:0]        sum;

  always #5 clk = ~clk;

  stage_classifier_sequencer #(
    .DATA_WIDTH_16           (DW),
    .NUM_CLASSIFIERS         (NC),
    .NUM_PARAM_PER_CLASSIFIER(NP),
    .NUM_STAGE_THRESHOLD     (NT),
    .ACC_WIDTH               (AW)
  ) dut (
    .clk_fpga          (clk),
    .reset_fpga        (rst),
    .i_db_ready        (db_ready),
    .i_rom             (rom),
    .i_start           (start),
    .o_busy            (busy),
    .o_param_valid     (pv),
    .i_param_ready     (pready),
    .o_classifier_index(cidx),
    .o_params          (params),
    .i_vote_valid      (vv),
    .i_vote            (vote),
    .o_done            (done),
    .o_stage_pass      (pass),
    .o_stage_sum       (sum)
  );

  int            n_pass = 0;
  int            n_total = 0;
  int            done_count = 0;
  int            model_idx = 0;
  int            model_sum = 0;
  logic [AW-1:0] model_sum_v = '0;
  bit            model_pass = 1'b0;
  int            seen[$];
  logic          pv_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NP*DW-1:0] exp_slice(input int k);
    logic [NP*DW-1:0] s;
    for (int j = 0; j < NP; j++) s[j*DW +: DW] = rom[(k*NP + j)*DW +: DW];
    return s;
  endfunction

  // Per-cycle comparison against the bench's own view of the transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (pv) begin
        chk("cmp_index", cidx, model_idx);
        chk("cmp_params", params, exp_slice(model_idx));
        chk("cmp_busy_while_valid", busy, 1);
        if (!pv_prev) seen.push_back(int'(cidx));
      end
      if (done) begin
        done_count++;
        chk("cmp_sum", sum, model_sum_v);
        chk("cmp_pass", pass, model_pass);
        chk("cmp_busy_in_done", busy, 0);
      end
    end
    pv_prev <= pv;
  end

  task automatic run_stage(input int v0, input int v1, input int v2, input int thr,
                           input int hold_cls, input int abort_cls, input bit poke);
    int votes[3];
    int dc0;
    logic [NP*DW-1:0] snap;
    votes = '{v0, v1, v2};
    rom[THR_W*DW +: DW] = 16'(thr);
    model_sum   = v0 + v1 + v2;
    model_sum_v = model_sum[AW-1:0];
    model_pass  = (model_sum >= thr);
    model_idx   = 0;
    seen.delete();
    dc0    = done_count;
    pready = (hold_cls != 0);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NC; k++) begin
      chk("issue_valid", pv, 1);
      if (k == hold_cls) begin
        snap = params;
        if (k == 1) chk("hold_word0", snap[DW-1:0], 16'hA013);
        for (int c = 0; c < 5; c++) begin
          vv = 1'b1; vote = 16'h7fff;
          @(posedge clk); #1;
          chk("hold_valid", pv, 1);
          chk("hold_params", params, snap);
        end
        pready = 1'b1;
        @(posedge clk); #1;
        vv = 1'b0;
      end else begin
        if (poke && k == 2) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("valid_drop", pv, 0);
      if (k == abort_cls) begin
        db_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", pv, 0);
        db_ready = 1'b1;
        pready   = 1'b1;
        return;
      end
      model_idx = k + 1;
      pready    = (hold_cls != k + 1);
      vv = 1'b1; vote = 16'(votes[k]);
      @(posedge clk); #1;
      vv = 1'b0;
    end
    chk("done_strobe", done, 1);
    chk("done_busy_low", busy, 0);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
    chk("done_count", done_count - dc0, 1);
    pready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc_abort;
    rst = 1'b1; db_ready = 1'b1; start = 1'b0; pready = 1'b1; vv = 1'b0; vote = '0;
    for (int w = 0; w < WORDS; w++) rom[w*DW +: DW] = 16'(16'hA000 + w);
    #7;
    chk("rst_busy", busy, 0);
    chk("rst_valid", pv, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sum", sum, 0);
    chk("rst_params", params, 0);
    chk("rst_index", cidx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_stage(100, -50, 20, 60, -1, -1, 1'b0);
    chk("t1_sum", sum, 20'h00046);
    chk("t1_pass", pass, 1);
    chk("t1_seen_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("t1_seen0", seen[0], 0);
      chk("t1_seen1", seen[1], 1);
      chk("t1_seen2", seen[2], 2);
    end

    run_stage(100, -50, 20, 71, -1, -1, 1'b0);
    chk("t2_sum", sum, 20'h00046);
    chk("t2_pass", pass, 0);

    run_stage(-32768, -32768, -32768, -32768, -1, -1, 1'b0);
    chk("t3_sum", sum, 20'hE8000);
    chk("t3_pass", pass, 0);

    run_stage(100, -50, 20, 60, 1, -1, 1'b0);
    chk("t4_sum", sum, 20'h00046);
    chk("t4_pass", pass, 1);

    db_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nodb_busy", busy, 0);
    @(posedge clk); #1;
    chk("nodb_busy2", busy, 0);
    chk("nodb_valid", pv, 0);
    db_ready = 1'b1;
    @(posedge clk); #1;

    run_stage(5, 6, 7, 18, -1, -1, 1'b1);
    chk("t6_sum", sum, 20'h00012);
    chk("t6_pass", pass, 1);

    dc_abort = done_count;
    run_stage(1, 2, 3, 0, -1, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_count - dc_abort, 0);
    chk("abort_sum_kept", sum, 20'h00012);
    chk("abort_pass_kept", pass, 1);

    model_idx = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_valid", pv, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", pv, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_params", params, 0);
    chk("mid_rst_index", cidx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_stage(100, -50, 20, 60, -1, -1, 1'b0);
    chk("t8_sum", sum, 20'h00046);
    chk("t8_pass", pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
